// File: rtl/generic_rom_pkg.sv
// Shared types and helpers for the generic_rom read adapter and its response FIFO.
package generic_rom_pkg;

   localparam int REQ_ALIGN_BITS = 2;

   typedef struct packed {
      logic valid;
      logic err;
   } rom_tag_t;

   // One extra MSB so wrapping pointers can tell full from empty.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/generic_rom_rsp_fifo.sv
// Response FIFO with wrap-bit pointers; push and pop may coincide at any occupancy.
// Head data is combinational from storage; writes are ignored only when full without a pop.
module generic_rom_rsp_fifo
   import generic_rom_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4,
   localparam int PTR_W = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [PTR_W-1:0] count,
   output logic             full,
   output logic             empty
);
   localparam int AW = PTR_W - 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign dout  = mem[rd_ptr[AW-1:0]];
   assign rd_en = pop && !empty;
   // When full, a simultaneous pop frees the very slot being written.
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/generic_rom_read_adapter.sv
// Valid/ready front-end for generic_rom: tag pipe tracks in-flight reads, FIFO buffers returns.
// Accept-to-response latency ROM_LATENCY+1; requests stall once FIFO plus in-flight reach RSP_DEPTH.
module generic_rom_read_adapter
   import generic_rom_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 10,
   parameter int ROM_LATENCY   = 2,
   parameter int RSP_DEPTH     = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic [ADDRESS_WIDTH+1:0]   i_req_addr,
   output logic                       o_rsp_valid,
   input  logic                       i_rsp_ready,
   output logic [DATA_WIDTH-1:0]      o_rsp_data,
   output logic                       o_rsp_err,
   output logic [ADDRESS_WIDTH-1:0]   o_rom_address,
   input  logic [DATA_WIDTH-1:0]      i_rom_read_data
);
   localparam int CNT_W  = ptr_w(RSP_DEPTH);
   localparam int FIFO_W = DATA_WIDTH + 1;

   rom_tag_t                 tag_pipe [ROM_LATENCY];
   rom_tag_t                 new_tag;
   logic [CNT_W-1:0]         inflight_count;
   logic [CNT_W-1:0]         fifo_count;
   logic [CNT_W:0]           credits_used;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic                     accept;
   logic                     misaligned;
   logic                     push;
   logic                     pop;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [FIFO_W-1:0]        fifo_din;
   logic [FIFO_W-1:0]        fifo_dout;

   // Credits depend only on registered counts, never on this cycle's handshakes.
   assign credits_used  = {1'b0, fifo_count} + {1'b0, inflight_count};
   assign o_req_ready   = !i_rst && !fifo_full && (credits_used < (CNT_W+1)'(RSP_DEPTH));

   assign misaligned    = |i_req_addr[REQ_ALIGN_BITS-1:0];
   assign accept        = i_req_valid && o_req_ready;
   assign o_rom_address = accept ? i_req_addr[ADDRESS_WIDTH+1:REQ_ALIGN_BITS] : addr_q;
   assign new_tag       = '{valid: accept, err: accept && misaligned};

   assign push     = tag_pipe[ROM_LATENCY-1].valid;
   assign fifo_din = tag_pipe[ROM_LATENCY-1].err ? {1'b1, {DATA_WIDTH{1'b0}}}
                                                 : {1'b0, i_rom_read_data};

   assign o_rsp_valid = !fifo_empty && !i_rst;
   assign o_rsp_err   = o_rsp_valid && fifo_dout[DATA_WIDTH];
   assign o_rsp_data  = o_rsp_valid ? fifo_dout[DATA_WIDTH-1:0] : '0;
   assign pop         = o_rsp_valid && i_rsp_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < ROM_LATENCY; i++) tag_pipe[i] <= '0;
         addr_q         <= '0;
         inflight_count <= '0;
      end else begin
         tag_pipe[0] <= new_tag;
         for (int i = 1; i < ROM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
         if (accept) addr_q <= i_req_addr[ADDRESS_WIDTH+1:REQ_ALIGN_BITS];
         case ({accept, push})
            2'b10:   inflight_count <= inflight_count + CNT_W'(1);
            2'b01:   inflight_count <= inflight_count - CNT_W'(1);
            default: inflight_count <= inflight_count;
         endcase
      end
   end

   generic_rom_rsp_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (RSP_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_generic_rom_read_adapter.sv
// Directed bench for generic_rom_read_adapter with a two-stage ROM model (rom[i] = A500_0000 + i).
module tb_generic_rom_read_adapter;
   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid;
   logic            req_ready;
   logic [AW+1:0]   req_addr;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW-1:0]   rsp_data;
   logic            rsp_err;
   logic [AW-1:0]   rom_address;
   logic [DW-1:0]   rom_read_data;
   logic [DW-1:0]   rom_q1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   generic_rom_read_adapter #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .ROM_LATENCY   (LAT),
      .RSP_DEPTH     (DEPTH)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_req_valid     (req_valid),
      .o_req_ready     (req_ready),
      .i_req_addr      (req_addr),
      .o_rsp_valid     (rsp_valid),
      .i_rsp_ready     (rsp_ready),
      .o_rsp_data      (rsp_data),
      .o_rsp_err       (rsp_err),
      .o_rom_address   (rom_address),
      .i_rom_read_data (rom_read_data)
   );

   always @(posedge clk) begin
      rom_q1        <= 32'hA500_0000 + DW'(rom_address);
      rom_read_data <= rom_q1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW:0] model(input logic [AW+1:0] a);
      if (a[1:0] != 2'b00) return {1'b1, {DW{1'b0}}};
      return {1'b0, 32'hA500_0000 + DW'(a[AW+1:2])};
   endfunction

   // Scoreboard and latency tracking, sampled mid-cycle.
   logic [DW:0] exp_q [$];
   int          acc_cyc_q [$];
   int          cyc = 0;
   int          n_rsp = 0;
   int          last_lat = 0;
   int          min_lat = 1000;
   int          max_lat = 0;
   int          max_out = 0;
   logic [DW:0] last_rsp;
   logic [DW:0] mon_e;
   int          mon_a;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         acc_cyc_q.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            last_rsp = {rsp_err, rsp_data};
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               mon_a = acc_cyc_q.pop_front();
               check("rsp_data", 64'({rsp_err, rsp_data}), 64'(mon_e));
               last_lat = cyc - mon_a;
               if (last_lat < min_lat) min_lat = last_lat;
               if (last_lat > max_lat) max_lat = last_lat;
            end
         end
         if (req_valid && req_ready) begin
            exp_q.push_back(model(req_addr));
            acc_cyc_q.push_back(cyc);
         end
         if (exp_q.size() > max_out) max_out = exp_q.size();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int b = 0;
      while ((exp_q.size() != 0 || rsp_valid) && b < 200) begin
         tick();
         b++;
      end
      if (b >= 200) check(tag, 64'd1, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int sent;
      int snap;
      int budget;
      logic will_acc;

      rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
      repeat (3) tick();
      check("reset_req_ready", 64'(req_ready), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_data", 64'(rsp_data), 64'd0);
      check("reset_rsp_err", 64'(rsp_err), 64'd0);
      check("reset_rom_addr", 64'(rom_address), 64'd0);
      rst = 1'b0;
      #1;
      check("ready_after_reset", 64'(req_ready), 64'd1);

      // 1: single aligned read of word 4
      req_valid = 1'b1; req_addr = 12'h010;
      #1;
      check("t1_rom_addr_comb", 64'(rom_address), 64'd4);
      tick();
      req_valid = 1'b0; req_addr = 12'h3FC;
      #1;
      check("t1_rom_addr_hold", 64'(rom_address), 64'd4);
      drain("t1_drain_timeout");
      check("t1_latency", 64'(last_lat), 64'd3);
      check("t1_data", 64'(last_rsp), 64'h0_A500_0004);

      // 2: burst of eight, consumer always ready
      max_lat = 0; snap = n_rsp;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1; req_addr = 12'(i * 4);
         check("t2_ready", 64'(req_ready), 64'd1);
         tick();
      end
      req_valid = 1'b0;
      drain("t2_drain_timeout");
      check("t2_count", 64'(n_rsp - snap), 64'd8);
      check("t2_max_latency", 64'(max_lat), 64'd3);
      check("t2_last", 64'(last_rsp), 64'h0_A500_0007);

      // 3: consumer stalled, credits must cap acceptance at four
      rsp_ready = 1'b0; acc = 0; snap = n_rsp;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1; req_addr = 12'(12'h040 + acc * 4);
         if (req_ready) acc++;
         tick();
      end
      check("t3_accepted", 64'(acc), 64'd4);
      check("t3_ready_low", 64'(req_ready), 64'd0);
      req_valid = 1'b0;
      repeat (3) tick();
      check("t3_rsp_held_valid", 64'(rsp_valid), 64'd1);
      check("t3_rsp_held_data", 64'({rsp_err, rsp_data}), 64'h0_A500_0010);
      rsp_ready = 1'b1;
      drain("t3_drain_timeout");
      check("t3_count", 64'(n_rsp - snap), 64'd4);
      check("t3_last", 64'(last_rsp), 64'h0_A500_0013);

      // 4: misaligned request sandwiched between aligned ones
      snap = n_rsp;
      req_valid = 1'b1; req_addr = 12'h00C; tick();
      req_addr = 12'h013; tick();
      req_addr = 12'h014; tick();
      req_valid = 1'b0;
      drain("t4_drain_timeout");
      check("t4_count", 64'(n_rsp - snap), 64'd3);
      check("t4_last", 64'(last_rsp), 64'h0_A500_0005);

      // 5: random valid/ready traffic
      snap = n_rsp; sent = 0; budget = 0; min_lat = 1000; max_out = 0;
      req_valid = 1'b0;
      while (sent < 2000 && budget < 20000) begin
         if (!req_valid) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) != 0) req_addr[1:0] = 2'b00;
         end
         rsp_ready = 1'($urandom_range(0, 1));
         #1;
         will_acc = req_valid && req_ready;
         tick();
         budget++;
         if (will_acc) begin
            sent++;
            req_valid = 1'b0;
         end
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      check("t5_sent", 64'(sent), 64'd2000);
      drain("t5_drain_timeout");
      check("t5_count", 64'(n_rsp - snap), 64'd2000);
      check("t5_min_latency_ge3", 64'(min_lat >= 3), 64'd1);
      check("t5_outstanding_le_depth", 64'(max_out <= DEPTH), 64'd1);

      // 6: reset with two in flight and two buffered
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_addr = 12'(12'h100 + i * 4);
         tick();
      end
      req_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; rsp_ready = 1'b1;
      #1;
      check("t6_ready_after_reset", 64'(req_ready), 64'd1);
      snap = n_rsp;
      repeat (8) tick();
      check("t6_no_stale_rsp", 64'(n_rsp - snap), 64'd0);
      check("t6_rsp_valid_low", 64'(rsp_valid), 64'd0);
      req_valid = 1'b1; req_addr = 12'h000;
      tick();
      req_valid = 1'b0;
      drain("t6_drain_timeout");
      check("t6_count", 64'(n_rsp - snap), 64'd1);
      check("t6_read0", 64'(last_rsp), 64'h0_A500_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
